// File: rtl/nn_pkg.sv
// nn_pkg: shared types and default widths for the training datapath.
package nn_pkg;
   localparam int NN_X_W = 4;
   localparam int NN_T_W = 4;
   typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
   typedef struct packed {
      logic [NN_X_W-1:0] x;
      logic [NN_T_W-1:0] target;
   } sample_t;
endpackage

// File: rtl/sample_regfile.sv
// sample_regfile: sample storage with one synchronous write port and one asynchronous read port.
module sample_regfile #(
   parameter int DEPTH = 8,
   parameter int W = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sample_buffer.sv
// sample_buffer: captures training pairs, then replays them to the network for a number of epochs.
module sample_buffer
   import nn_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int X_W = NN_X_W,
   parameter int T_W = NN_T_W,
   parameter int EPOCH_W = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               wr_en_i,
   input  logic [X_W-1:0]     wr_x_i,
   input  logic [T_W-1:0]     wr_t_i,
   input  logic [EPOCH_W-1:0] epoch_limit_i,
   input  logic               start_i,
   input  logic               sample_ready_i,
   output logic               sample_valid_o,
   output logic [X_W-1:0]     x_o,
   output logic [T_W-1:0]     target_o,
   output logic [AW-1:0]      idx_o,
   output logic [AW:0]        count_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               overflow_o,
   output logic [EPOCH_W-1:0] epoch_o,
   output logic               epoch_done_o,
   output logic               done_o
);
   state_t               state_q, state_d;
   logic [AW:0]          count_q, count_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d, idx_q;
   logic [EPOCH_W-1:0]   epoch_q, epoch_d, epoch_inc;
   logic                 overflow_q, overflow_d, edone_q, edone_d, wr, wrap;
   logic [X_W+T_W-1:0]   rd_data, nxt;
   logic [X_W-1:0]       x_q;
   logic [T_W-1:0]       t_q;

   sample_regfile #(.DEPTH(DEPTH), .W(X_W+T_W)) u_regfile (
      .clk_i   (clk_i),
      .we_i    (wr),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i ({wr_x_i, wr_t_i}),
      .raddr_i (rd_ptr_d),
      .rdata_o (rd_data)
   );

   assign full_o    = count_q == (AW+1)'(DEPTH);
   assign empty_o   = count_q == '0;
   assign wrap      = (AW+1)'(rd_ptr_q) + (AW+1)'(1) >= count_q;
   assign epoch_inc = epoch_q + EPOCH_W'(1);
   // A start in the same cycle as the first write must see the sample being written.
   assign nxt = (wr && count_q[AW-1:0] == rd_ptr_d) ? {wr_x_i, wr_t_i} : rd_data;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      epoch_d    = epoch_q;
      overflow_d = overflow_q;
      edone_d    = 1'b0;
      wr         = 1'b0;
      if (clear_i) begin
         state_d    = LOAD;
         count_d    = '0;
         rd_ptr_d   = '0;
         epoch_d    = '0;
         overflow_d = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               wr         = wr_en_i & ~full_o;
               count_d    = count_q + (AW+1)'(wr);
               overflow_d = overflow_q | (wr_en_i & full_o);
               if (start_i && (!empty_o || wr)) begin
                  state_d  = RUN;
                  rd_ptr_d = '0;
                  epoch_d  = '0;
               end
            end
            RUN: if (sample_ready_i) begin
               rd_ptr_d = wrap ? '0 : rd_ptr_q + AW'(1);
               epoch_d  = wrap ? epoch_inc : epoch_q;
               edone_d  = wrap;
               if (wrap && epoch_limit_i != '0 && epoch_inc == epoch_limit_i) state_d = DONE;
            end
            DONE: if (start_i) begin
               state_d  = RUN;
               rd_ptr_d = '0;
               epoch_d  = '0;
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= LOAD;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         epoch_q    <= '0;
         overflow_q <= 1'b0;
         edone_q    <= 1'b0;
         x_q        <= '0;
         t_q        <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         epoch_q    <= epoch_d;
         overflow_q <= overflow_d;
         edone_q    <= edone_d;
         if (state_d == RUN) begin
            {x_q, t_q} <= nxt;
            idx_q      <= rd_ptr_d;
         end
      end
   end

   assign sample_valid_o = state_q == RUN;
   assign done_o         = state_q == DONE;
   assign x_o            = x_q;
   assign target_o       = t_q;
   assign idx_o          = idx_q;
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;
   assign epoch_o        = epoch_q;
   assign epoch_done_o   = edone_q;
endmodule

// File: tb/tb_sample_buffer.sv
// tb_sample_buffer: random and directed stimulus checked every cycle against a queue-based model.
module tb_sample_buffer;
   import nn_pkg::*;
   localparam int DEPTH = 8, X_W = 4, T_W = 4, EPOCH_W = 8, AW = 3;

   logic clk_i = 0, rst_i = 0, clear_i = 0, wr_en_i = 0, start_i = 0, sample_ready_i = 0;
   logic [X_W-1:0] wr_x_i = '0;
   logic [T_W-1:0] wr_t_i = '0;
   logic [EPOCH_W-1:0] epoch_limit_i = '0;
   logic sample_valid_o, full_o, empty_o, overflow_o, epoch_done_o, done_o;
   logic [X_W-1:0] x_o;
   logic [T_W-1:0] target_o;
   logic [AW-1:0] idx_o;
   logic [AW:0] count_o;
   logic [EPOCH_W-1:0] epoch_o;

   sample_buffer #(.DEPTH(DEPTH), .X_W(X_W), .T_W(T_W), .EPOCH_W(EPOCH_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .wr_en_i(wr_en_i),
      .wr_x_i(wr_x_i), .wr_t_i(wr_t_i), .epoch_limit_i(epoch_limit_i),
      .start_i(start_i), .sample_ready_i(sample_ready_i),
      .sample_valid_o(sample_valid_o), .x_o(x_o), .target_o(target_o), .idx_o(idx_o),
      .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
      .epoch_o(epoch_o), .epoch_done_o(epoch_done_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: the stored samples as a queue, a replay position and a mode.
   sample_t q[$];
   sample_t cur;
   int pos, ep, cur_idx;
   bit run, fin, ovf, edone;

   function automatic void model_reset();
      q.delete();
      pos = 0; ep = 0; cur_idx = 0; cur = '0;
      run = 0; fin = 0; ovf = 0; edone = 0;
   endfunction

   function automatic void begin_run();
      run = 1; fin = 0; pos = 0; ep = 0;
      cur = q[0]; cur_idx = 0;
   endfunction

   function automatic void model_step();
      edone = 0;
      if (clear_i) begin
         q.delete(); pos = 0; ep = 0; ovf = 0; run = 0; fin = 0;
      end else if (!run && !fin) begin
         if (wr_en_i) begin
            if (q.size() < DEPTH) q.push_back(sample_t'{x: wr_x_i, target: wr_t_i});
            else ovf = 1;
         end
         if (start_i && q.size() > 0) begin_run();
      end else if (run) begin
         if (sample_ready_i) begin
            if (pos + 1 < q.size()) pos++;
            else begin
               pos = 0;
               ep = (ep + 1) % 256;
               edone = 1;
               if (epoch_limit_i != 0 && ep == int'(epoch_limit_i)) begin
                  run = 0; fin = 1;
               end
            end
            if (run) begin
               cur = q[pos]; cur_idx = pos;
            end
         end
      end else if (start_i) begin_run();
   endfunction

   function automatic void compare();
      chk("valid", sample_valid_o, run);
      chk("done", done_o, fin);
      chk("x", x_o, cur.x);
      chk("target", target_o, cur.target);
      chk("idx", idx_o, cur_idx);
      chk("count", count_o, q.size());
      chk("full", full_o, q.size() == DEPTH);
      chk("empty", empty_o, q.size() == 0);
      chk("overflow", overflow_o, ovf);
      chk("epoch", epoch_o, ep);
      chk("epoch_done", epoch_done_o, edone);
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) model_step();
      #1 compare();
   end

   task automatic tick();
      @(negedge clk_i);
   endtask

   int exp_seq[6] = '{1, 3, 5, 1, 3, 5};

   initial begin
      model_reset();
      epoch_limit_i = 8'd2;
      repeat (2) tick();
      rst_i = 1;
      // Load three pairs and start.
      wr_en_i = 1; wr_x_i = 1; wr_t_i = 2; tick();
      wr_x_i = 3; wr_t_i = 4; tick();
      wr_x_i = 5; wr_t_i = 6; tick();
      wr_en_i = 0; start_i = 1; tick();
      start_i = 0;
      chk("first_valid", sample_valid_o, 1);
      chk("first_x", x_o, 1);
      chk("first_t", target_o, 2);
      chk("first_idx", idx_o, 0);
      chk("first_count", count_o, 3);
      // Two epochs with ready held high.
      sample_ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         chk("seq_x", x_o, exp_seq[i]);
         tick();
         chk("seq_edone", epoch_done_o, (i == 2 || i == 5));
      end
      sample_ready_i = 0;
      chk("lim_done", done_o, 1);
      chk("lim_epoch", epoch_o, 2);
      chk("lim_valid", sample_valid_o, 0);
      chk("lim_hold_x", x_o, 5);
      // Overflow: nine writes into eight slots.
      clear_i = 1; tick(); clear_i = 0;
      epoch_limit_i = 0;
      for (int i = 0; i < 9; i++) begin
         wr_en_i = 1; wr_x_i = 4'(i + 1); wr_t_i = 4'(i + 8); tick();
      end
      wr_en_i = 0;
      chk("ovf_full", full_o, 1);
      chk("ovf_count", count_o, 8);
      chk("ovf_flag", overflow_o, 1);
      start_i = 1; tick(); start_i = 0;
      sample_ready_i = 1; repeat (7) tick(); sample_ready_i = 0;
      chk("slot7_idx", idx_o, 7);
      chk("slot7_x", x_o, 8);
      chk("slot7_t", target_o, 15);
      // Start while empty, then start together with the first write.
      clear_i = 1; tick(); clear_i = 0;
      start_i = 1; tick();
      chk("empty_start_valid", sample_valid_o, 0);
      wr_en_i = 1; wr_x_i = 7; wr_t_i = 9; tick();
      start_i = 0; wr_en_i = 0;
      chk("same_cycle_valid", sample_valid_o, 1);
      chk("same_cycle_x", x_o, 7);
      chk("same_cycle_t", target_o, 9);
      chk("same_cycle_count", count_o, 1);
      // Unlimited epochs with a single sample: the counter wraps through 256.
      sample_ready_i = 1; repeat (300) tick(); sample_ready_i = 0;
      chk("wrap_epoch", epoch_o, 300 % 256);
      chk("wrap_valid", sample_valid_o, 1);
      // Clear beats a same-cycle handshake.
      sample_ready_i = 1; clear_i = 1; tick();
      sample_ready_i = 0; clear_i = 0;
      chk("clr_valid", sample_valid_o, 0);
      chk("clr_count", count_o, 0);
      chk("clr_epoch", epoch_o, 0);
      chk("clr_ovf", overflow_o, 0);
      // Asynchronous reset in the middle of a run.
      wr_en_i = 1; wr_x_i = 4; wr_t_i = 11; tick();
      wr_x_i = 6; wr_t_i = 13; start_i = 1; tick();
      wr_en_i = 0; start_i = 0; sample_ready_i = 1; tick();
      sample_ready_i = 0;
      #2 rst_i = 0;
      model_reset();
      #1;
      chk("arst_valid", sample_valid_o, 0);
      chk("arst_x", x_o, 0);
      chk("arst_t", target_o, 0);
      chk("arst_idx", idx_o, 0);
      chk("arst_count", count_o, 0);
      chk("arst_epoch", epoch_o, 0);
      tick();
      rst_i = 1;
      tick();
      chk("arst_empty", empty_o, 1);
      chk("arst_load_valid", sample_valid_o, 0);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         clear_i = ($urandom % 80) == 0;
         wr_en_i = ($urandom % 3) == 0;
         wr_x_i = 4'($urandom);
         wr_t_i = 4'($urandom);
         start_i = ($urandom % 12) == 0;
         sample_ready_i = $urandom % 2;
         if ($urandom % 50 == 0) epoch_limit_i = 8'($urandom % 4);
         tick();
      end
      clear_i = 0; wr_en_i = 0; start_i = 0; sample_ready_i = 0;
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sample_buffer.md
Name: sample_buffer

Overview:
- Upstream stage of the training datapath: captures (input x, target) training pairs from the pins into a small register file.
- Replays the stored pairs to the forward/backprop network one sample at a time, for a programmed number of epochs.
- Presents x to the hidden neurons and target to the output neuron's loss/init input.
- Accepts a consume handshake from the training state machine when a sample's forward + backward pass completes.

Parameters:
- DEPTH, 8, number of sample slots (power of two, ≥2)
- X_W, 4, width of one input vector x
- T_W, 4, width of one target value
- EPOCH_W, 8, width of the epoch counter and epoch limit

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low (0 = reset)
- clear_i  in  1  synchronous flush; returns to LOAD with count 0
- wr_en_i  in  1  write strobe; one sample captured per high cycle
- wr_x_i  in  X_W  sample input vector
- wr_t_i  in  T_W  sample target
- epoch_limit_i  in  EPOCH_W  epochs to run; 0 = run forever
- start_i  in  1  begin replay
- sample_ready_i  in  1  network has consumed the current sample
- sample_valid_o  out  1  x_o/target_o are valid
- x_o  out  X_W  current sample input
- target_o  out  T_W  current sample target
- idx_o  out  $clog2(DEPTH)  slot index of current sample
- count_o  out  $clog2(DEPTH)+1  samples stored
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- overflow_o  out  1  sticky: write attempted while full
- epoch_o  out  EPOCH_W  completed epochs
- epoch_done_o  out  1  one-cycle pulse at each epoch wrap
- done_o  out  1  high in DONE

Behaviour:
- Reset values:
  - state LOAD; count, rd_ptr, epoch_o = 0
  - sample_valid_o, epoch_done_o, done_o, overflow_o = 0
  - x_o, target_o, idx_o = 0
  - storage contents are don't-care, no reset required
- States: LOAD, RUN, DONE. The state register is the only control register.
- LOAD:
  - wr_en_i & !full_o → mem[count] <= {wr_x_i, wr_t_i}; count += 1 next cycle.
  - wr_en_i & full_o → no write; overflow_o <= 1 (sticky until reset or clear_i).
  - start_i & !empty_o → RUN next cycle; rd_ptr = 0, epoch_o = 0.
  - start_i while empty → ignored, stay in LOAD.
  - start_i & wr_en_i in the same cycle → write is performed and RUN entered; the new sample is included in count.
- RUN:
  - sample_valid_o = 1 from the first RUN cycle; latency start_i → valid is exactly 1 cycle.
  - x_o / target_o / idx_o reflect mem[rd_ptr] and rd_ptr, as registered outputs updated with rd_ptr.
  - wr_en_i is ignored in RUN; it does not set overflow_o.
  - sample_ready_i & sample_valid_o:
    - rd_ptr+1 < count → rd_ptr += 1.
    - otherwise (wrap) → rd_ptr = 0, epoch_o += 1, epoch_done_o pulses 1 cycle.
    - If the incremented epoch equals a non-zero epoch_limit_i, go to DONE instead of continuing.
  - epoch_limit_i == 0 → never leaves RUN by epoch count; epoch_o wraps modulo 2^EPOCH_W and epoch_done_o still pulses.
  - sample_ready_i without sample_valid_o → ignored.
  - count == 1 → every accepted handshake is an epoch wrap.
- DONE:
  - sample_valid_o = 0; done_o = 1; epoch_o holds its final value; x_o/target_o hold their last values.
  - start_i → RUN again from rd_ptr 0, epoch_o cleared; stored samples are retained.
- clear_i (any state):
  - next cycle LOAD; count, rd_ptr, epoch_o, overflow_o = 0; valid/done = 0.
  - clear_i has priority over wr_en_i, start_i and sample_ready_i in the same cycle.
- Reset mid-RUN: outputs go to reset values immediately (asynchronous); no partial epoch is retained.
- epoch_limit_i is sampled continuously; changing it mid-RUN takes effect at the next wrap.
- Widths: count_o needs $clog2(DEPTH)+1 bits so that DEPTH is representable. All comparisons are unsigned.

Decomposition:
- Shared package nn_pkg:
  - state enum (LOAD, RUN, DONE)
  - X_W, T_W defaults
  - sample_t packed struct {x, target}
- One natural sub-module: sample_regfile — DEPTH x (X_W+T_W) storage, one synchronous write port, one asynchronous read port.
- The control FSM and counters stay in sample_buffer.

Test Plan:
- Load 3 samples (x=1,t=2), (x=3,t=4), (x=5,t=6), pulse start_i → next cycle valid=1, x_o=1, target_o=2, idx_o=0, count_o=3.
- Epoch limit: epoch_limit_i=2, sample_ready_i held high → sequence x=1,3,5,1,3,5; epoch_done_o pulses after each x=5; then done_o=1, epoch_o=2, valid=0.
- Overflow: write 9 samples with DEPTH=8 → full_o=1, count_o=8, overflow_o=1; slot 7 holds the 8th sample.
- Empty start: start_i with count 0 → stays LOAD, valid=0; same-cycle start_i+wr_en_i(x=7,t=9) → RUN with x_o=7, count_o=1.
- Clear priority: clear_i with sample_ready_i mid-RUN → next cycle LOAD, count_o=0, epoch_o=0, overflow_o=0, valid=0.
- Async reset asserted mid-RUN between clock edges → all outputs 0 before the next edge; after release, LOAD with empty_o=1.
